// File: rtl/soc_led_pwm.sv
// LED/PWM controller: an Avalon-MM register bank drives WIDTH registered outputs.
// Each output is either static or gated by a shared prescaled 8-bit PWM.
module soc_led_pwm #(
  parameter int unsigned WIDTH       = 14,
  parameter int unsigned PRE_W       = 16,
  parameter logic [31:0] RESET_VALUE = 32'd0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] A_DATA     = 3'd0;
  localparam logic [2:0] A_SET      = 3'd1;
  localparam logic [2:0] A_CLR      = 3'd2;
  localparam logic [2:0] A_TOGGLE   = 3'd3;
  localparam logic [2:0] A_MODE     = 3'd4;
  localparam logic [2:0] A_DUTY     = 3'd5;
  localparam logic [2:0] A_PRESCALE = 3'd6;
  localparam logic [2:0] A_PHASE    = 3'd7;

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] mode_q;
  logic [7:0]       duty_q;
  logic [7:0]       phase_q;
  logic [PRE_W-1:0] prescale_q;
  logic [PRE_W-1:0] pre_cnt_q;

  logic             wr_en;
  logic             pre_wr;
  logic             tick;
  logic             pwm_on;
  logic [WIDTH-1:0] wd_w;
  logic             unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign wd_w      = writedata[WIDTH-1:0];
  assign pre_wr    = wr_en && (address == A_PRESCALE);
  // A PRESCALE write restarts the count and suppresses the tick of that cycle.
  assign tick      = !pre_wr && (pre_cnt_q == prescale_q);
  assign pwm_on    = phase_q < duty_q;
  assign unused_wd = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= RESET_VALUE[WIDTH-1:0];
      mode_q     <= '0;
      duty_q     <= 8'h80;
      prescale_q <= '0;
    end else if (wr_en) begin
      case (address)
        A_DATA:     data_q     <= wd_w;
        A_SET:      data_q     <= data_q | wd_w;
        A_CLR:      data_q     <= data_q & ~wd_w;
        A_TOGGLE:   data_q     <= data_q ^ wd_w;
        A_MODE:     mode_q     <= wd_w;
        A_DUTY:     duty_q     <= writedata[7:0];
        A_PRESCALE: prescale_q <= writedata[PRE_W-1:0];
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt_q <= '0;
      phase_q   <= '0;
    end else begin
      if (pre_wr || tick) pre_cnt_q <= '0;
      else                pre_cnt_q <= pre_cnt_q + 1'b1;
      if (tick)           phase_q   <= phase_q + 8'd1;
    end
  end

  // Static channels pass DATA; PWM channels are gated by pwm_on.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) out_port <= RESET_VALUE[WIDTH-1:0];
    else          out_port <= data_q & (~mode_q | {WIDTH{pwm_on}});
  end

  always_comb begin
    readdata = '0;
    case (address)
      A_DATA:     readdata[WIDTH-1:0] = data_q;
      A_MODE:     readdata[WIDTH-1:0] = mode_q;
      A_DUTY:     readdata[7:0]       = duty_q;
      A_PRESCALE: readdata[PRE_W-1:0] = prescale_q;
      A_PHASE:    readdata[7:0]       = phase_q;
      default:    readdata            = '0;
    endcase
  end

endmodule

// File: tb/tb_soc_led_pwm.sv
// Bench for soc_led_pwm: directed spec scenarios plus random bus traffic,
// scored against a cycle-level reference model through expectation queues.
module tb_soc_led_pwm;

  localparam int W  = 14;
  localparam int PW = 16;
  localparam logic [31:0] MASK  = (W == 32) ? 32'hFFFF_FFFF : ((32'd1 << W) - 32'd1);
  localparam logic [31:0] PMASK = (PW == 32) ? 32'hFFFF_FFFF : ((32'd1 << PW) - 32'd1);
  localparam logic [31:0] RSTV  = 32'd0;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  out_port;

  int tests = 0;
  int fails = 0;

  soc_led_pwm #(.WIDTH(W), .PRE_W(PW), .RESET_VALUE(RSTV)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  always #5 clk = ~clk;

  // Reference model state (plain arithmetic on integers)
  logic [31:0] m_data, m_mode, m_duty, m_pre, m_cnt, m_phase;
  logic [31:0] exp_q[$];
  logic [34:0] rd_q[$];

  function automatic logic [31:0] model_out();
    logic [31:0] pwm_mask;
    pwm_mask = (m_phase < m_duty) ? 32'hFFFF_FFFF : ~m_mode;
    return m_data & pwm_mask & MASK;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return m_data;
      3'd4: return m_mode;
      3'd5: return m_duty;
      3'd6: return m_pre;
      3'd7: return m_phase;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data = RSTV & MASK; m_mode = 0; m_duty = 32'h80;
      m_pre = 0; m_cnt = 0; m_phase = 0;
      exp_q.delete(); rd_q.delete();
      exp_q.push_back(RSTV & MASK);
    end else begin
      logic [31:0] e;
      logic wr, prewr, tk;
      e     = model_out();
      wr    = chipselect && !write_n;
      prewr = wr && (address == 3'd6);
      tk    = !prewr && (m_cnt == m_pre);
      m_cnt = (prewr || tk) ? 32'd0 : m_cnt + 1;
      if (tk) m_phase = (m_phase + 1) % 256;
      if (wr) begin
        case (address)
          3'd0: m_data = writedata & MASK;
          3'd1: m_data = m_data | (writedata & MASK);
          3'd2: m_data = m_data & ~(writedata & MASK);
          3'd3: m_data = m_data ^ (writedata & MASK);
          3'd4: m_mode = writedata & MASK;
          3'd5: m_duty = writedata & 32'hFF;
          3'd6: m_pre  = writedata & PMASK;
          default: ;
        endcase
      end
      exp_q.push_back(e);
    end
  end

  // Monitor: compares presented outputs against queued expectations
  always @(negedge clk) begin
    logic [31:0] e;
    logic [34:0] r;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (32'(out_port) !== e) begin
        fails++;
        $display("FAIL out_port: got %h expected %h at %0t", out_port, e[W-1:0], $time);
      end
    end
    if (rd_q.size() > 0) begin
      r = rd_q.pop_front();
      tests++;
      if (readdata !== r[31:0]) begin
        fails++;
        $display("FAIL readdata addr%0d: got %h expected %h at %0t", r[34:32], readdata, r[31:0], $time);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] wd);
    @(posedge clk); #1;
    chipselect = cs; write_n = wn; address = a; writedata = wd;
    rd_q.push_back({a, model_read(a)});
  endtask

  task automatic count_hi(input int n, output int hi0, output int hi13);
    hi0 = 0; hi13 = 0;
    for (int k = 0; k < n; k++) begin
      bus(1'b0, 1'b1, 3'd7, 32'd0);
      @(negedge clk);
      hi0  += int'(out_port[0]);
      hi13 += int'(out_port[13]);
    end
  endtask

  initial begin
    int h0, h13;
    logic [2:0] a;
    logic [31:0] wd;
    bit reached;
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    address = 3'd7;
    #1;
    chk("rst_out", 32'(out_port), 32'h0);
    chk("rst_phase", readdata, 32'h0);
    bus(1'b0, 1'b1, 3'd5, 32'd0); #1 chk("rst_duty", readdata, 32'h80);
    bus(1'b0, 1'b1, 3'd4, 32'd0); #1 chk("rst_mode", readdata, 32'h0);

    bus(1'b1, 1'b0, 3'd0, 32'hFFFF_1234);
    bus(1'b0, 1'b1, 3'd0, 32'd0); #1 chk("data_rd", readdata, 32'h1234);
    bus(1'b0, 1'b1, 3'd0, 32'd0); #1 chk("data_out", 32'(out_port), 32'h1234);

    bus(1'b1, 1'b0, 3'd1, 32'h0003);
    bus(1'b1, 1'b0, 3'd2, 32'h1000);
    bus(1'b1, 1'b0, 3'd3, 32'h00F0);
    bus(1'b0, 1'b1, 3'd1, 32'd0); #1 chk("set_rd", readdata, 32'h0);
    bus(1'b0, 1'b1, 3'd2, 32'd0); #1 chk("clr_rd", readdata, 32'h0);
    bus(1'b0, 1'b1, 3'd3, 32'd0); #1 chk("tog_rd", readdata, 32'h0);
    chk("sct_out", 32'(out_port), 32'h02C7);
    bus(1'b0, 1'b1, 3'd0, 32'd0); #1 chk("sct_data", readdata, 32'h02C7);

    // PWM: channel 0 modulated, channel 13 static
    bus(1'b1, 1'b0, 3'd5, 32'd64);
    bus(1'b1, 1'b0, 3'd4, 32'h0001);
    bus(1'b1, 1'b0, 3'd0, 32'h2001);
    repeat (3) bus(1'b0, 1'b1, 3'd7, 32'd0);
    count_hi(256, h0, h13);
    chk("duty64_p0", h0, 64); chk("static_p0", h13, 256);
    bus(1'b1, 1'b0, 3'd6, 32'hABCD_0003);
    repeat (3) bus(1'b0, 1'b1, 3'd6, 32'd0);
    count_hi(1024, h0, h13);
    chk("duty64_p3", h0, 256); chk("static_p3", h13, 1024);
    bus(1'b1, 1'b0, 3'd6, 32'd0);
    bus(1'b1, 1'b0, 3'd5, 32'd0);
    repeat (3) bus(1'b0, 1'b1, 3'd7, 32'd0);
    count_hi(512, h0, h13);
    chk("duty0", h0, 0); chk("static_d0", h13, 512);
    bus(1'b1, 1'b0, 3'd5, 32'd255);
    repeat (3) bus(1'b0, 1'b1, 3'd7, 32'd0);
    count_hi(256, h0, h13);
    chk("duty255", h0, 255); chk("static_d255", h13, 256);

    // Asynchronous reset in the middle of a PWM period
    bus(1'b1, 1'b0, 3'd5, 32'd128);
    bus(1'b1, 1'b1, 3'd7, 32'd0);
    reached = 1'b0;
    for (int i = 0; i < 300 && !reached; i++) begin
      bus(1'b0, 1'b1, 3'd7, 32'd0);
      if (m_phase == 32'd100) reached = 1'b1;
    end
    chk("phase100_reached", 32'(reached), 32'd1);
    #1 chk("phase100", readdata, 32'd100);
    reset_n = 1'b0;
    #1;
    chk("arst_out", 32'(out_port), 32'h0);
    chk("arst_phase", readdata, 32'h0);
    bus(1'b0, 1'b1, 3'd5, 32'd0);
    bus(1'b0, 1'b1, 3'd7, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    address = 3'd7; #1 chk("rel_phase", readdata, 32'h0);
    bus(1'b1, 1'b0, 3'd4, 32'h1);
    bus(1'b1, 1'b0, 3'd0, 32'h1);
    bus(1'b0, 1'b1, 3'd5, 32'd0); #1 chk("rel_duty", readdata, 32'h80);
    bus(1'b0, 1'b1, 3'd7, 32'd0);
    count_hi(256, h0, h13);
    chk("rel_pwm", h0, 128);

    // Random traffic, including ignored PHASE writes and deselected writes
    for (int i = 0; i < 1500; i++) begin
      a  = 3'($urandom_range(0, 7));
      wd = $urandom();
      if (a == 3'd6) wd = {16'($urandom()), 16'($urandom_range(0, 4))};
      bus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, wd);
    end
    repeat (3) bus(1'b0, 1'b1, 3'd0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/soc_led_pwm.md
SOC_LED_PWM -- requirements
Module: soc_led_pwm

Interface
REQ-001 SHALL have parameter WIDTH, default 14: output channel count, legal range 1..32.
REQ-002 SHALL have parameter PRE_W, default 16: prescaler width, legal range 1..32.
REQ-003 SHALL have parameter RESET_VALUE, default 0: reset value of the DATA register, truncated to WIDTH.
REQ-004 SHALL have port clk, input, 1: system clock, all state on rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port address, input, 3: Avalon-MM word address.
REQ-007 SHALL have port chipselect, input, 1: slave select.
REQ-008 SHALL have port write_n, input, 1: active-low write strobe.
REQ-009 SHALL have port writedata, input, 32: write data.
REQ-010 SHALL have port readdata, output, 32: read data, zero-extended.
REQ-011 SHALL have port out_port, output, WIDTH: registered channel outputs.

Function
REQ-012 SHALL accept a write when chipselect=1 and write_n=0, with the update taking effect on that clock edge and no wait states.
REQ-013 SHALL use this register map: 0 DATA (R/W), 1 SET (W), 2 CLR (W), 3 TOGGLE (W), 4 MODE (R/W, WIDTH bits), 5 DUTY (R/W, 8 bits), 6 PRESCALE (R/W, PRE_W bits), 7 PHASE (RO, 8 bits).
REQ-014 SHALL perform these writes: SET does DATA |= writedata; CLR does DATA &= ~writedata; TOGGLE does DATA ^= writedata; each uses writedata[WIDTH-1:0] only, and upper bits are ignored.
REQ-015 SHALL drive readdata combinationally from address with zero read latency; chipselect is not required for reads; unused upper bits read 0; SET, CLR and TOGGLE read 0.
REQ-016 SHALL run a prescaler counter 0..PRESCALE that wraps to 0 and asserts a one-cycle tick on the wrap cycle; PRESCALE=0 gives a tick every clock.
REQ-017 SHALL reset the prescaler counter to 0 on any PRESCALE write, with no tick on that cycle.
REQ-018 SHALL increment the 8-bit phase counter on each tick, wrapping from 255 to 0.
REQ-019 SHALL compute pwm_on = (phase < DUTY), unsigned; DUTY=0 keeps pwm_on at 0; DUTY=255 gives 255/256 on.
REQ-020 SHALL register the output as next out_port[i] = DATA[i] & (MODE[i] ? pwm_on : 1), giving one clock latency from a register write to out_port.
REQ-021 SHALL make a DUTY write visible to the comparison on the cycle after the write, without resetting the phase counter.
REQ-022 SHALL compare a phase increment and a DUTY write in the same cycle as old DUTY against old phase, with the new values used from the next cycle.
REQ-023 SHALL ignore writes to PHASE and writes when chipselect=0.

Reset
REQ-024 SHALL, on reset_n=0 and immediately (asynchronous), set DATA=RESET_VALUE, MODE=0, DUTY=0x80, PRESCALE=0, prescaler=0, phase=0, out_port=RESET_VALUE[WIDTH-1:0].
REQ-025 SHALL, on reset deassertion, operate from the first rising clk edge; a reset applied mid-PWM-period abandons that period.

Verification
REQ-026 Reset (WIDTH=14) -> out_port=0x0000; read addr5=0x00000080, addr4=0, addr7=0.
REQ-027 Write 0xFFFF1234 to addr0 -> out_port=0x1234 one cycle later; read addr0=0x00001234.
REQ-028 From DATA=0x1234: SET 0x0003, then CLR 0x1000, then TOGGLE 0x00F0 -> DATA/out_port=0x02C7; read addr1..3=0.
REQ-029 DATA=0x0001, MODE=0x0001, DUTY=64, PRESCALE=0 -> out_port[0] high 64 of every 256 clocks; PRESCALE=3 -> 256 of every 1024 clocks.
REQ-030 DUTY=0 -> out_port[0]=0 for 512 clocks; DUTY=255 -> exactly 1 low clock per 256; MODE=0 channels stay static throughout.
REQ-031 Assert reset_n mid-PWM with phase=100 -> out_port=0x0000 and phase=0 without a clock edge; after release, PWM restarts from phase 0 with DUTY=0x80.
